// File: rtl/acc_core_seq.sv
// Multi-cycle accumulator sequencer: fetch/decode/execute over a shared RAM
// with the W register and carry/zero flags mirrored into memory-mapped words.
module acc_core_seq (
  input  logic        clk,
  input  logic        reset_bar,
  output logic [10:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] wreg,
  output logic        flag_c,
  output logic        flag_z,
  output logic [8:0]  pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_OWAIT, S_EXEC, S_STORE, S_HALT
  } state_t;

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00, OP_LDI  = 5'h01, OP_LDW  = 5'h02, OP_STW  = 5'h03,
    OP_ADDW = 5'h04, OP_SUBW = 5'h05, OP_ANDW = 5'h06, OP_ORW  = 5'h07,
    OP_XORW = 5'h08, OP_ADCW = 5'h09, OP_JMP  = 5'h0A, OP_JZ   = 5'h0B,
    OP_JC   = 5'h0C, OP_HALT = 5'h1F
  } opcode_t;

  localparam logic [10:0] ADDR_FLAG_C = 11'h201;
  localparam logic [10:0] ADDR_FLAG_Z = 11'h202;

  state_t      state;
  // Only the opcode of the latched instruction is needed after decode;
  // the operand has already been driven onto mem_addr by then.
  logic [4:0]  ir_op;

  logic [4:0]  dec_op;
  logic [10:0] dec_opd;
  logic [8:0]  pc_next;
  logic        take;
  logic [16:0] sum;
  logic [15:0] alu_w;
  logic        alu_c;

  assign dec_op  = mem_rdata[15:11];
  assign dec_opd = mem_rdata[10:0];
  assign pc_next = pc + 9'd1;

  // Branch condition for the instruction currently on mem_rdata.
  always_comb begin
    take = 1'b0;
    case (dec_op)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = flag_z;
      OP_JC:   take = flag_c;
      default: take = 1'b0;
    endcase
  end

  // 17-bit ALU for the execute cycle; C passes through for logical ops/LDW.
  always_comb begin
    sum   = '0;
    alu_w = wreg;
    alu_c = flag_c;
    case (ir_op)
      OP_LDW:  alu_w = mem_rdata;
      OP_ADDW: begin
        sum   = {1'b0, wreg} + {1'b0, mem_rdata};
        alu_w = sum[15:0];
        alu_c = sum[16];
      end
      OP_SUBW: begin
        sum   = {1'b0, wreg} - {1'b0, mem_rdata};
        alu_w = sum[15:0];
        alu_c = ~sum[16];
      end
      OP_ANDW: alu_w = wreg & mem_rdata;
      OP_ORW:  alu_w = wreg | mem_rdata;
      OP_XORW: alu_w = wreg ^ mem_rdata;
      OP_ADCW: begin
        sum   = {1'b0, wreg} + {1'b0, mem_rdata} + {16'b0, flag_c};
        alu_w = sum[15:0];
        alu_c = sum[16];
      end
      default: ;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state     <= S_FETCH;
      ir_op     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      wreg      <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      pc        <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          mem_addr <= {2'b00, pc};
          state    <= S_FWAIT;
        end
        S_FWAIT: state <= S_DECODE;
        S_DECODE: begin
          ir_op    <= dec_op;
          pc       <= pc_next;
          mem_addr <= {2'b00, pc_next};
          state    <= S_FWAIT;
          case (dec_op)
            OP_NOP: ;
            OP_LDI: begin
              wreg   <= {5'b0, dec_opd};
              flag_z <= (dec_opd == '0);
            end
            OP_JMP, OP_JZ, OP_JC: begin
              if (take) begin
                pc       <= dec_opd[8:0];
                mem_addr <= {2'b00, dec_opd[8:0]};
              end
            end
            OP_LDW, OP_ADDW, OP_SUBW, OP_ANDW, OP_ORW, OP_XORW, OP_ADCW: begin
              mem_addr <= dec_opd;
              state    <= S_OWAIT;
            end
            OP_STW: begin
              mem_addr  <= dec_opd;
              mem_wdata <= wreg;
              mem_we    <= 1'b1;
              state     <= S_STORE;
              // Flag stores land here so the flag is settled before the write negedge.
              if (dec_opd == ADDR_FLAG_C) flag_c <= wreg[0];
              if (dec_opd == ADDR_FLAG_Z) flag_z <= wreg[0];
            end
            OP_HALT: begin
              halted   <= 1'b1;
              mem_addr <= mem_addr;
              state    <= S_HALT;
            end
            default: illegal <= 1'b1;
          endcase
        end
        S_OWAIT: state <= S_EXEC;
        S_EXEC: begin
          wreg     <= alu_w;
          flag_c   <= alu_c;
          flag_z   <= (alu_w == '0);
          mem_addr <= {2'b00, pc};
          state    <= S_FWAIT;
        end
        S_STORE: begin
          mem_we   <= 1'b0;
          mem_addr <= {2'b00, pc};
          state    <= S_FWAIT;
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_core_seq.sv
// Bench for acc_core_seq: RAM model with mapped W/C/Z words, instruction-level
// reference model run in lockstep, directed programs plus random programs.
module tb_acc_core_seq;

  logic        clk;
  logic        reset_bar;
  logic [10:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] wreg;
  logic        flag_c;
  logic        flag_z;
  logic [8:0]  pc;
  logic        halted;
  logic        illegal;

  acc_core_seq dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .wreg      (wreg),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read on rising edge, write on falling edge, mapped W/C/Z words.
  logic [15:0] ram [0:2047];

  always @(posedge clk) begin
    case (mem_addr)
      11'h200: mem_rdata <= wreg;
      11'h201: mem_rdata <= {15'b0, flag_c};
      11'h202: mem_rdata <= {15'b0, flag_z};
      default: mem_rdata <= ram[mem_addr];
    endcase
  end

  always @(negedge clk) begin
    if (mem_we && (mem_addr < 11'h200 || mem_addr > 11'h202))
      ram[mem_addr] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural reference model.
  logic [15:0] mm [0:2047];
  logic [15:0] m_w;
  logic        m_c, m_z, m_halt, m_ill;
  logic [8:0]  m_pc;
  logic [10:0] m_addr;
  logic [15:0] m_wdata;

  function automatic logic [15:0] m_rd(input logic [10:0] a);
    if (a == 11'h200) return m_w;
    if (a == 11'h201) return {15'b0, m_c};
    if (a == 11'h202) return {15'b0, m_z};
    return mm[a];
  endfunction

  task automatic m_step(output int cyc, output bit st, output logic [10:0] sa);
    logic [15:0] ir, mv;
    int unsigned op, t;
    logic [10:0] a;
    ir   = mm[m_pc];
    op   = ir[15:11];
    a    = ir[10:0];
    m_pc = 9'((int'(m_pc) + 1) % 512);
    cyc  = 2;
    st   = 0;
    sa   = a;
    mv   = m_rd(a);
    case (op)
      0: ;
      1: begin m_w = {5'b0, a}; m_z = (m_w == 0); end
      3: begin
        cyc = 3; st = 1; m_wdata = m_w;
        if (a == 11'h201) m_c = m_w[0];
        else if (a == 11'h202) m_z = m_w[0];
        else if (a != 11'h200) mm[a] = m_w;
      end
      2, 4, 5, 6, 7, 8, 9: begin
        cyc = 4;
        case (op)
          2: m_w = mv;
          4: begin t = m_w + mv; m_c = (t > 65535); m_w = 16'(t); end
          5: begin m_c = (m_w >= mv); m_w = 16'(int'(m_w) - int'(mv)); end
          6: m_w = m_w & mv;
          7: m_w = m_w | mv;
          8: m_w = m_w ^ mv;
          default: begin t = m_w + mv + m_c; m_c = (t > 65535); m_w = 16'(t); end
        endcase
        m_z = (m_w == 0);
      end
      10: m_pc = a[8:0];
      11: if (m_z) m_pc = a[8:0];
      12: if (m_c) m_pc = a[8:0];
      31: m_halt = 1;
      default: m_ill = 1;
    endcase
    if (!m_halt) m_addr = {2'b00, m_pc};
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, ":w"},   wreg, m_w);
    chk({tag, ":cz"},  {flag_c, flag_z}, {m_c, m_z});
    chk({tag, ":pc"},  pc, m_pc);
    chk({tag, ":bus"}, {mem_addr, mem_wdata, mem_we}, {m_addr, m_wdata, 1'b0});
    chk({tag, ":hi"},  {halted, illegal}, {m_halt, m_ill});
  endtask

  task automatic put(input int a, input logic [15:0] v);
    ram[a] = v;
    mm[a]  = v;
  endtask

  task automatic load_blank();
    for (int i = 0; i < 2048; i++) put(i, 16'h0000);
  endtask

  function automatic logic [15:0] rand_instr();
    int unsigned r, op;
    logic [10:0] a;
    r = $urandom_range(0, 99);
    if (r < 1) op = 31;
    else if (r < 4) op = $urandom_range(13, 30);
    else op = $urandom_range(0, 12);
    a = 11'($urandom);
    if (op >= 2 && op <= 9 && $urandom_range(0, 7) == 0)
      a = 11'(11'h200 + $urandom_range(0, 3));
    return {5'(op), a};
  endfunction

  task automatic load_rand();
    for (int i = 0; i < 2048; i++)
      put(i, (i < 512) ? rand_instr() : 16'($urandom));
  endtask

  task automatic hold_reset();
    reset_bar = 1'b0;
    #2;
  endtask

  // Release reset, then run up to n instructions in lockstep with the model.
  task automatic run(input int n);
    int cyc;
    bit st;
    logic [10:0] sa;
    m_w = 0; m_c = 0; m_z = 0; m_halt = 0; m_ill = 0;
    m_pc = 0; m_addr = 0; m_wdata = 0;
    @(negedge clk);
    reset_bar = 1'b1;
    @(posedge clk);
    for (int i = 0; i < n && !m_halt; i++) begin
      m_step(cyc, st, sa);
      if (st) begin
        repeat (2) @(posedge clk);
        #1;
        chk("st_we", mem_we, 1'b1);
        chk("st_addr", mem_addr, sa);
        chk("st_data", mem_wdata, m_wdata);
        chk("st_flags", {flag_c, flag_z}, {m_c, m_z});
        @(posedge clk);
      end else begin
        repeat (cyc) @(posedge clk);
      end
      #1;
      chk_arch("instr");
    end
    if (m_halt) begin
      repeat (100) begin
        @(posedge clk);
        #1;
        chk_arch("halt_frz");
      end
    end
  endtask

  initial begin
    reset_bar = 1'b0;
    #2;
    chk("rst_state", {mem_addr, mem_wdata, mem_we, wreg, flag_c, flag_z, pc, halted, illegal}, '0);

    // Reset during STORE before the write negedge.
    load_blank();
    put(0, 16'h0923);
    put(1, 16'h1810);
    put(16, 16'h1234);
    @(negedge clk);
    reset_bar = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_we_pre", mem_we, 1'b1);
    reset_bar = 1'b0;
    #1;
    chk("rst_zero", {mem_addr, mem_wdata, mem_we, wreg, flag_c, flag_z, pc, halted, illegal}, '0);
    @(negedge clk);
    #1;
    chk("rst_nowrite", ram[16], 16'h1234);
    reset_bar = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_e2_pc", pc, 9'h000);
    @(posedge clk);
    #1;
    chk("rst_e3_pc", pc, 9'h001);
    chk("rst_e3_w", wreg, 16'h0123);

    // LDI 0x7FF; STW 0x010; ADDW 0x010; HALT
    hold_reset();
    load_blank();
    put(0, 16'h0FFF); put(1, 16'h1810); put(2, 16'h2010); put(3, 16'hF800);
    run(10);
    chk("t1_w", wreg, 16'h0FFE);
    chk("t1_cz", {flag_c, flag_z}, 2'b00);
    chk("t1_ram", ram[16], 16'h07FF);

    // LDI 1; SUBW [1]; SUBW [2]; HALT
    hold_reset();
    load_blank();
    put(0, 16'h0801); put(1, 16'h2820); put(2, 16'h2821); put(3, 16'hF800);
    put(32, 16'h0001); put(33, 16'h0002);
    run(2);
    chk("t2a_w", wreg, 16'h0000);
    chk("t2a_cz", {flag_c, flag_z}, 2'b11);
    hold_reset();
    run(10);
    chk("t2b_w", wreg, 16'hFFFE);
    chk("t2b_cz", {flag_c, flag_z}, 2'b00);

    // LDI 1; STW 0x201; JC 0x050
    hold_reset();
    load_blank();
    put(0, 16'h0801); put(1, 16'h1A01); put(2, 16'h6050); put(16'h050, 16'hF800);
    run(3);
    chk("t3_pc", pc, 9'h050);
    chk("t3_c", flag_c, 1'b1);

    // PC wrap: JMP 0x1FF; NOP at 0x1FF
    hold_reset();
    load_blank();
    put(0, 16'h51FF);
    run(2);
    chk("t4_pc", pc, 9'h000);
    chk("t4_addr", mem_addr, 11'h000);

    // Illegal opcode then HALT at 0x003
    hold_reset();
    load_blank();
    put(0, 16'h0805); put(1, 16'hA800); put(2, 16'h0000); put(3, 16'hF800);
    run(10);
    chk("t5_ill", illegal, 1'b1);
    chk("t5_halt", halted, 1'b1);
    chk("t5_pc", pc, 9'h004);
    chk("t5_w", wreg, 16'h0005);

    // Random programs.
    for (int k = 0; k < 6; k++) begin
      hold_reset();
      load_rand();
      run(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
